// File: rtl/decoder_riscv_pkg.sv
// Shared constants, decoded-control bundle and safe default for the RV32I decode stage.
// Define DECODER_RV32M_EN to decode the M-extension (multiply/divide) encodings.
package decoder_riscv_pkg;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLTS = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_EQ   = 5'b11000;
    localparam logic [4:0] ALU_NE   = 5'b11001;
    localparam logic [4:0] ALU_LTS  = 5'b11100;
    localparam logic [4:0] ALU_GES  = 5'b11101;
    localparam logic [4:0] ALU_LTU  = 5'b11110;
    localparam logic [4:0] ALU_GEU  = 5'b11111;

    localparam logic [1:0] OP_A_RS1     = 2'd0;
    localparam logic [1:0] OP_A_CURR_PC = 2'd1;
    localparam logic [1:0] OP_A_ZERO    = 2'd2;

    localparam logic [2:0] OP_B_RS2   = 3'd0;
    localparam logic [2:0] OP_B_IMM_I = 3'd1;
    localparam logic [2:0] OP_B_IMM_U = 3'd2;
    localparam logic [2:0] OP_B_IMM_S = 3'd3;
    localparam logic [2:0] OP_B_INCR  = 3'd4;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    localparam logic WB_EX_RESULT = 1'b0;
    localparam logic WB_LSU_DATA  = 1'b1;

    typedef struct packed {
        logic [1:0] op_a_sel;
        logic [2:0] op_b_sel;
        logic [4:0] alu_op;
        logic       mem_req;
        logic       mem_we;
        logic [2:0] mem_size;
        logic       gpr_we;
        logic       wb_src_sel;
        logic       illegal_instr;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       mdu_req;
        logic [2:0] mdu_op;
    } decoded_ctrl_t;

    // Side-effect-free bundle: used at reset and as the base for illegal instructions.
    function automatic decoded_ctrl_t ctrl_default();
        decoded_ctrl_t c;
        c               = '0;
        c.op_a_sel      = OP_A_RS1;
        c.op_b_sel      = OP_B_IMM_I;
        c.alu_op        = ALU_ADD;
        c.mem_size      = LDST_B;
        c.wb_src_sel    = WB_EX_RESULT;
        return c;
    endfunction

endpackage

// File: rtl/decoder_riscv_core.sv
// Purely combinational RV32I instruction decoder producing a decoded_ctrl_t bundle.
// Define DECODER_RV32M_EN to accept OP encodings with funct7=0000001 as MDU requests.
module decoder_riscv_core
    import decoder_riscv_pkg::*;
(
    input  logic [31:0]   instr,
    output decoded_ctrl_t ctrl
);

    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;
    logic       unused_fields;

    assign opcode        = instr[6:2];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        ctrl  = ctrl_default();
        legal = 1'b1;
        case (opcode)
            OPC_LOAD: begin
                ctrl.mem_req    = 1'b1;
                ctrl.gpr_we     = 1'b1;
                ctrl.wb_src_sel = WB_LSU_DATA;
                ctrl.mem_size   = funct3;
                legal           = !(funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
            end
            OPC_STORE: begin
                ctrl.op_b_sel = OP_B_IMM_S;
                ctrl.mem_req  = 1'b1;
                ctrl.mem_we   = 1'b1;
                ctrl.mem_size = funct3;
                legal         = (funct3 <= 3'd2);
            end
            OPC_OP_IMM: begin
                ctrl.gpr_we = 1'b1;
                // Only the shift-immediates give meaning to imm[11:5].
                case (funct3)
                    3'd1: begin
                        ctrl.alu_op = ALU_SLL;
                        legal       = (funct7 == 7'b0000000);
                    end
                    3'd5: begin
                        if (funct7 == 7'b0000000)      ctrl.alu_op = ALU_SRL;
                        else if (funct7 == 7'b0100000) ctrl.alu_op = ALU_SRA;
                        else                           legal = 1'b0;
                    end
                    default: ctrl.alu_op = {2'b00, funct3};
                endcase
            end
            OPC_OP: begin
                ctrl.op_b_sel = OP_B_RS2;
                ctrl.gpr_we   = 1'b1;
                if (funct7 == 7'b0000000)
                    ctrl.alu_op = {2'b00, funct3};
                else if (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5))
                    ctrl.alu_op = {2'b01, funct3};
`ifdef DECODER_RV32M_EN
                else if (funct7 == 7'b0000001) begin
                    ctrl.mdu_req = 1'b1;
                    ctrl.mdu_op  = funct3;
                end
`endif
                else
                    legal = 1'b0;
            end
            OPC_LUI: begin
                ctrl.op_a_sel = OP_A_ZERO;
                ctrl.op_b_sel = OP_B_IMM_U;
                ctrl.gpr_we   = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.op_a_sel = OP_A_CURR_PC;
                ctrl.op_b_sel = OP_B_IMM_U;
                ctrl.gpr_we   = 1'b1;
            end
            OPC_BRANCH: begin
                // Branch compare codes are {2'b11, funct3} for every defined funct3.
                ctrl.op_b_sel = OP_B_RS2;
                ctrl.branch   = 1'b1;
                ctrl.alu_op   = {2'b11, funct3};
                legal         = !(funct3 == 3'd2 || funct3 == 3'd3);
            end
            OPC_JAL: begin
                ctrl.op_a_sel = OP_A_CURR_PC;
                ctrl.op_b_sel = OP_B_INCR;
                ctrl.jal      = 1'b1;
                ctrl.gpr_we   = 1'b1;
            end
            OPC_JALR: begin
                ctrl.op_a_sel = OP_A_CURR_PC;
                ctrl.op_b_sel = OP_B_INCR;
                ctrl.jalr     = 1'b1;
                ctrl.gpr_we   = 1'b1;
                legal         = (funct3 == 3'd0);
            end
            OPC_MISC_MEM: legal = 1'b1;
            default:      legal = 1'b0;
        endcase

        if (instr[1:0] != 2'b11)
            legal = 1'b0;

        if (!legal) begin
            ctrl               = ctrl_default();
            ctrl.illegal_instr = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_riscv_stage.sv
// Registered RV32I decode stage: input queue, combinational decode, output register, illegal counter.
// Define DECODER_RV32M_EN to decode multiply/divide; otherwise mdu_req_o/mdu_op_o stay 0.
module decoder_riscv_stage
    import decoder_riscv_pkg::*;
#(
    parameter int INSTR_FIFO_DEPTH = 2,
    parameter int ILLEGAL_CNT_W    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     instr_valid_i,
    output logic                     instr_ready_o,
    input  logic [31:0]              instr_i,
    input  logic [31:0]              pc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              pc_o,
    output logic [31:0]              instr_o,
    output logic [1:0]               ex_op_a_sel_o,
    output logic [2:0]               ex_op_b_sel_o,
    output logic [4:0]               alu_op_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [2:0]               mem_size_o,
    output logic                     gpr_we_a_o,
    output logic                     wb_src_sel_o,
    output logic                     illegal_instr_o,
    output logic                     branch_o,
    output logic                     jal_o,
    output logic                     jalr_o,
    output logic                     mdu_req_o,
    output logic [2:0]               mdu_op_o,
    output logic [ILLEGAL_CNT_W-1:0] illegal_cnt_o
);

    // Both sides use valid/ready: a transfer happens on an edge where valid and ready are
    // both high; valid never waits on ready, and a bundle is held stable until accepted.

    localparam int AW = $clog2(INSTR_FIFO_DEPTH);

    logic [31:0]              q_instr [INSTR_FIFO_DEPTH];
    logic [31:0]              q_pc    [INSTR_FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW:0]              count;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     load;

    decoded_ctrl_t            head_ctrl;
    decoded_ctrl_t            out_ctrl;
    logic                     out_valid;
    logic [31:0]              out_pc;
    logic [31:0]              out_instr;
    logic [ILLEGAL_CNT_W-1:0] illegal_cnt;

    assign full          = (count == (AW+1)'(INSTR_FIFO_DEPTH));
    assign empty         = (count == '0);
    assign instr_ready_o = !full;
    assign push          = instr_valid_i && !full;
    assign load          = !empty && (!out_valid || out_ready_i);

    decoder_riscv_core u_core (
        .instr (q_instr[rd_ptr]),
        .ctrl  (head_ctrl)
    );

    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            q_instr[wr_ptr] <= instr_i;
            q_pc[wr_ptr]    <= pc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(load);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid <= 1'b0;
            out_ctrl  <= ctrl_default();
            out_pc    <= '0;
            out_instr <= '0;
        end else if (flush_i) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_ctrl  <= head_ctrl;
            out_pc    <= q_pc[rd_ptr];
            out_instr <= q_instr[rd_ptr];
        end else if (out_ready_i) begin
            out_valid <= 1'b0;
        end
    end

    // Counts delivered illegal instructions; a flush cycle leaves it untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            illegal_cnt <= '0;
        else if (!flush_i && out_valid && out_ready_i && out_ctrl.illegal_instr
                 && illegal_cnt != '1)
            illegal_cnt <= illegal_cnt + ILLEGAL_CNT_W'(1);
    end

    assign out_valid_o     = out_valid;
    assign pc_o            = out_pc;
    assign instr_o         = out_instr;
    assign ex_op_a_sel_o   = out_ctrl.op_a_sel;
    assign ex_op_b_sel_o   = out_ctrl.op_b_sel;
    assign alu_op_o        = out_ctrl.alu_op;
    assign mem_req_o       = out_ctrl.mem_req;
    assign mem_we_o        = out_ctrl.mem_we;
    assign mem_size_o      = out_ctrl.mem_size;
    assign gpr_we_a_o      = out_ctrl.gpr_we;
    assign wb_src_sel_o    = out_ctrl.wb_src_sel;
    assign illegal_instr_o = out_ctrl.illegal_instr;
    assign branch_o        = out_ctrl.branch;
    assign jal_o           = out_ctrl.jal;
    assign jalr_o          = out_ctrl.jalr;
    assign mdu_req_o       = out_ctrl.mdu_req;
    assign mdu_op_o        = out_ctrl.mdu_op;
    assign illegal_cnt_o   = illegal_cnt;

endmodule

// File: doc/decoder_riscv_stage.md
Name: decoder_riscv_stage

Overview:
- Registered RV32I decode stage with valid/ready handshakes on both sides. Sits between fetch and execute.
- Input queue of INSTR_FIFO_DEPTH entries absorbs execute back-pressure. A combinational decode core feeds an output register.
- Decodes every RV32I opcode. Counts illegal instructions. Supports pipeline flush.

Parameters:
- INSTR_FIFO_DEPTH, 2, input queue entries; power of two, >=2.
- ILLEGAL_CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  discard queued and registered instructions.
- instr_valid_i  in  1  fetch presents instruction.
- instr_ready_o  out  1  stage can accept.
- instr_i  in  32  fetched instruction.
- pc_i  in  32  its PC.
- out_valid_o  out  1  decoded bundle valid.
- out_ready_i  in  1  execute accepts bundle.
- pc_o / instr_o  out  32 / 32  carried PC and raw instruction.
- ex_op_a_sel_o 2, ex_op_b_sel_o 3, alu_op_o 5, mem_req_o 1, mem_we_o 1, mem_size_o 3, gpr_we_a_o 1, wb_src_sel_o 1, illegal_instr_o 1, branch_o 1, jal_o 1, jalr_o 1  out  decoded controls; encodings per defines_riscv.v.
- mdu_req_o  out  1  multiply/divide request (optional feature).
- mdu_op_o  out  3  multiply/divide op, equal to funct3 (optional feature).
- illegal_cnt_o  out  ILLEGAL_CNT_W  illegal instructions delivered since reset.

Behaviour:
- Reset (rst_i high at edge):
  - Queue empty; out_valid_o=0; illegal_cnt_o=0.
  - All control outputs 0, except ex_op_a_sel_o=OP_A_RS1, ex_op_b_sel_o=OP_B_IMM_I, alu_op_o=ALU_ADD, mem_size_o=LDST_B, wb_src_sel_o=WB_EX_RESULT.
  - pc_o/instr_o=0.
  - Reset overrides flush and handshakes in the same cycle.
- Input handshake:
  - instr_ready_o = !queue_full, independent of out_ready_i.
  - Push when instr_valid_i && instr_ready_o.
- Output register:
  - Loads the decoded queue head when the queue is non-empty and (!out_valid_o || out_ready_i); the head pops the same edge.
  - Otherwise it holds and all outputs stay stable while out_valid_o && !out_ready_i.
  - out_valid_o clears on (out_ready_i && queue empty).
- Latency:
  - Push at edge k -> bundle visible after edge k+1; minimum 2 cycles accept-to-valid.
  - Throughput is 1/cycle when out_ready_i stays high.
- Capacity: INSTR_FIFO_DEPTH + 1 instructions in flight (queue plus output register).
- Queue pointers wrap modulo depth; count width is log2(depth)+1.
- Pushing and popping in the same cycle is legal whenever not full.
- Flush:
  - flush_i at an edge empties the queue and clears out_valid_o.
  - A push or output load requested in the same cycle is discarded.
  - The counter is unchanged.
- Decode (opcode=instr[6:2]; instr[1:0]!=2'b11 is illegal):
  - LOAD: ADD, rs1+imm_I, mem_req=1, gpr_we=1, wb=LSU, size=funct3. funct3 in {3,6,7} is illegal.
  - STORE: rs1+imm_S, mem_req=1, mem_we=1. funct3>2 is illegal.
  - OP_IMM / OP: alu_op={funct7[5],funct3} where defined, gpr_we=1. Undefined funct7 is illegal; shift-immediates also check imm[11:5].
  - LUI: op_a=ZERO, op_b=IMM_U. AUIPC: op_a=PC, op_b=IMM_U. Both gpr_we=1.
  - BRANCH: branch_o=1, alu_op=compare per funct3. funct3 in {2,3} is illegal.
  - JAL: jal_o=1, gpr_we=1, op_a=PC, op_b=INCR.
  - JALR: jalr_o=1, same op_a/op_b as JAL. funct3!=0 is illegal.
  - MISC_MEM: no side effects.
  - SYSTEM and all other opcodes: illegal.
- Any illegal instruction forces mem_req, mem_we, gpr_we, branch, jal, jalr and mdu_req to 0; size=LDST_B; illegal_instr_o=1.
- illegal_cnt_o increments on each out_valid_o && out_ready_i && illegal_instr_o transfer. It saturates at all-ones.

Optional Feature:
- DECODER_RV32M_EN defined:
  - OP with funct7=7'b0000001 decodes to mdu_req_o=1, mdu_op_o=funct3, gpr_we=1, legal.
- Not defined:
  - That encoding is illegal.
  - mdu_req_o and mdu_op_o are tied 0.

Decomposition:
- Package decoder_riscv_pkg:
  - opcode constants, ALU op codes, operand-select codes, LDST sizes, WB codes.
  - typedef struct decoded_ctrl_t covering all control outputs.
  - function for the reset/safe default.
- Sub-module decoder_riscv_core: purely combinational, instr[31:0] -> decoded_ctrl_t.
- Queue, output register and counter live in the top module.

Test Plan:
- Reset mid-stream:
  - Stimulus: 2 queued instructions, out_valid_o=1; assert rst_i one cycle.
  - Required response: next cycle out_valid_o=0, instr_ready_o=1, illegal_cnt_o=0, defaults on all controls.
- Load:
  - Stimulus: lw x1,4(x2) = 32'h00412083 at pc 32'h100, out_ready_i=1.
  - Required response: 2 cycles later out_valid_o=1, mem_req=1, mem_we=0, mem_size=3'd2, wb=LSU, gpr_we=1, pc_o=32'h100.
- Illegal load:
  - Stimulus: 32'h00413083 (funct3=3).
  - Required response: illegal_instr_o=1, mem_req=0, gpr_we=0; illegal_cnt_o becomes 1 after the transfer.
- Back-pressure:
  - Stimulus: out_ready_i=0, INSTR_FIFO_DEPTH=2, stream 4 instructions.
  - Required response: exactly 3 accepted, instr_ready_o low, outputs stable. Raising out_ready_i delivers them in order at 1/cycle.
- Flush:
  - Stimulus: 3 in flight; flush_i together with a push.
  - Required response: next cycle out_valid_o=0, queue empty, the pushed instruction never appears.
- Saturation and RV32M:
  - Stimulus: ILLEGAL_CNT_W=2, 5 illegal transfers.
  - Required response: counter reads 3.
  - Stimulus: mul = 32'h022081b3.
  - Required response: mdu_req_o=1 with DECODER_RV32M_EN defined; illegal_instr_o=1 without it.
